uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `UART_TX` serializer between `NUM_REQ` byte-stream requesters. A requester wins the transmitter for a whole frame, optionally prefixed with a one-byte ID header. The block issues one `i_TX_DV` pulse per byte and paces bytes on the serializer's `o_TX_Done`. It sits between the on-chip byte producers and the single UART TX pin driver.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner selection for one shared UART_TX: a winner keeps the serializer for a whole frame (optional ID header first).
// Byte accepted on N is strobed on N+1; ready only while the serializer is idle, and the next byte comes no earlier than 2 clocks after i_TX_Done.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int HEADER_EN = 1
) (
   input  logic                   i_Clock,
   input  logic                   i_Rst,
   input  logic [NUM_REQ-1:0]     i_Req_Valid,
   input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
   input  logic [NUM_REQ-1:0]     i_Req_Last,
   output logic [NUM_REQ-1:0]     o_Req_Ready,
   output logic                   o_TX_DV,
   output logic [7:0]             o_TX_Byte,
   input  logic                   i_TX_Active,
   input  logic                   i_TX_Done,
   output logic [NUM_REQ-1:0]     o_Grant,
   output logic                   o_Busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_LOAD, S_WAIT} state_t;

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
   logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
   logic [IDX_W-1:0]   w_win_idx, w_idx, w_rr_next;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
   logic               r_last, w_last_nxt;
   logic               r_tx_dv, w_tx_dv_nxt;
   logic [7:0]         r_tx_byte, w_tx_byte_nxt;
   logic [7:0]         w_lane_byte, w_hdr_byte;
   logic               w_any_req, w_lane_valid, w_lane_last, w_accept;

   // First requester at or above rr_ptr, wrapping around.
   always_comb begin
      w_any_req = 1'b0;
      w_win_idx = '0;
      w_idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
         if (!w_any_req && i_Req_Valid[w_idx]) begin
            w_any_req = 1'b1;
            w_win_idx = w_idx;
         end
      end
   end

   always_comb begin
      w_lane_byte = '0;
      for (int n = 0; n < NUM_REQ; n++) begin
         if (r_grant[n]) w_lane_byte = i_Req_Byte[8*n +: 8];
      end
   end

   assign w_lane_valid = |(i_Req_Valid & r_grant);
   assign w_lane_last  = |(i_Req_Last & r_grant);
   assign o_Req_Ready  = (r_state == S_DATA && !i_TX_Active) ? r_grant : '0;
   assign w_accept     = (r_state == S_DATA) && !i_TX_Active && w_lane_valid;
   assign w_rr_next    = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
   assign w_hdr_byte   = 8'hA0 | 8'(r_gnt_idx);

   always_comb begin
      w_state_nxt   = r_state;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_gnt_idx_nxt = r_gnt_idx;
      w_grant_nxt   = r_grant;
      w_last_nxt    = r_last;
      w_tx_byte_nxt = r_tx_byte;
      w_tx_dv_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_gnt_idx_nxt = w_win_idx;
               w_grant_nxt   = NUM_REQ'(1) << w_win_idx;
               w_state_nxt   = (HEADER_EN != 0) ? S_HDR : S_DATA;
            end
         end
         S_HDR: begin
            if (!i_TX_Active) begin
               w_tx_byte_nxt = w_hdr_byte;
               w_tx_dv_nxt   = 1'b1;
               w_last_nxt    = 1'b0;
               w_state_nxt   = S_WAIT;
            end
         end
         S_DATA: begin
            if (w_accept) begin
               w_tx_byte_nxt = w_lane_byte;
               w_last_nxt    = w_lane_last;
               w_tx_dv_nxt   = 1'b1;
               w_state_nxt   = S_LOAD;
            end
         end
         S_LOAD: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (i_TX_Done) begin
               if (r_last) begin
                  w_grant_nxt  = '0;
                  w_rr_ptr_nxt = w_rr_next;
                  w_state_nxt  = S_IDLE;
               end else begin
                  w_state_nxt  = S_DATA;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_gnt_idx <= '0;
         r_grant   <= '0;
         r_last    <= 1'b0;
         r_tx_dv   <= 1'b0;
         r_tx_byte <= 8'h00;
      end else begin
         r_state   <= w_state_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_gnt_idx <= w_gnt_idx_nxt;
         r_grant   <= w_grant_nxt;
         r_last    <= w_last_nxt;
         r_tx_dv   <= w_tx_dv_nxt;
         r_tx_byte <= w_tx_byte_nxt;
      end
   end

   assign o_TX_DV   = r_tx_dv;
   assign o_TX_Byte = r_tx_byte;
   assign o_Grant   = r_grant;
   assign o_Busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: serializer stub, per-lane byte producers and a frame-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int N     = 4;
   localparam int FRAME = 40;
   localparam int LIMIT = 20000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid, req_last, req_ready, grant;
   logic [8*N-1:0] req_byte;
   logic           tx_dv, tx_active, tx_done, busy;
   logic [7:0]     tx_byte;

   logic [1:0]  n_valid, n_last, n_ready, n_grant;
   logic [15:0] n_byte;
   logic        n_dv, n_active, n_done, n_busy;
   logic [7:0]  n_txb;

   uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(1)) dut (
      .i_Clock(clk), .i_Rst(rst), .i_Req_Valid(req_valid), .i_Req_Byte(req_byte),
      .i_Req_Last(req_last), .o_Req_Ready(req_ready), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
      .i_TX_Active(tx_active), .i_TX_Done(tx_done), .o_Grant(grant), .o_Busy(busy));

   uart_tx_arbiter #(.NUM_REQ(2), .HEADER_EN(0)) dut_nh (
      .i_Clock(clk), .i_Rst(rst), .i_Req_Valid(n_valid), .i_Req_Byte(n_byte),
      .i_Req_Last(n_last), .o_Req_Ready(n_ready), .o_TX_DV(n_dv), .o_TX_Byte(n_txb),
      .i_TX_Active(n_active), .i_TX_Done(n_done), .o_Grant(n_grant), .o_Busy(n_busy));

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [8:0]  lane_q [N][$];
   logic [8:0]  mdl_q  [N][$];
   logic [11:0] exp_q  [$];
   int          model_ptr = 0;
   int          dv_cnt = 0;
   logic [N-1:0] stall_force = '0;
   bit          rand_stall = 1'b0;
   int          n_dv_cnt = 0;
   logic [7:0]  n_last_byte = 8'h00;

   task automatic push_byte(input int lane, input logic [7:0] b, input logic l);
      lane_q[lane].push_back({l, b});
      mdl_q[lane].push_back({l, b});
   endtask

   // Whole frames in round-robin order from the model's pointer; each becomes header + payload.
   task automatic model_append();
      int win;
      logic [8:0] e;
      forever begin
         win = -1;
         for (int i = 0; i < N; i++)
            if (win < 0 && mdl_q[(model_ptr + i) % N].size() > 0) win = (model_ptr + i) % N;
         if (win < 0) break;
         exp_q.push_back({4'(win), 8'hA0 | 8'(win)});
         do begin
            e = mdl_q[win].pop_front();
            exp_q.push_back({4'(win), e[7:0]});
         end while (!e[8] && mdl_q[win].size() > 0);
         model_ptr = (win + 1) % N;
      end
   endtask

   task automatic clear_all();
      for (int n = 0; n < N; n++) begin
         lane_q[n].delete();
         mdl_q[n].delete();
      end
      exp_q.delete();
      model_ptr = 0;
      stall_force = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_all();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while ((exp_q.size() != 0 || busy || tx_active) && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      check_eq({tag, "_done_in_time"}, 32'(t < LIMIT), 1);
      check_eq({tag, "_grant_idle"}, 32'(grant), 0);
      check_eq({tag, "_busy_idle"}, 32'(busy), 0);
   endtask

   task automatic wait_lane(input int lane, input int sz, input string tag);
      int t = 0;
      while (lane_q[lane].size() != sz && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      check_eq({tag, "_reached"}, 32'(t < LIMIT), 1);
   endtask

   // Producers, serializer stub and strobe monitor for the main instance.
   initial begin
      logic prev_dv, pend_dv, coin;
      int stub_cnt;
      logic [7:0] stub_byte;
      logic [N-1:0] hs;
      logic [11:0] ex;
      logic [8:0] e;
      req_valid = '0; req_byte = '0; req_last = '0;
      tx_active = 1'b0; tx_done = 1'b0;
      prev_dv = 1'b0; pend_dv = 1'b0; stub_cnt = 0; stub_byte = 8'h00;
      forever begin
         @(negedge clk);
         pend_dv = 1'b0;
         if (!rst) begin
            if (tx_done) check_eq("tx_byte_held", 32'(tx_byte), 32'(stub_byte));
            if (tx_dv) begin
               dv_cnt++;
               check_eq("dv_back_to_back", 32'(prev_dv), 0);
               check_eq("dv_while_tx_active", 32'(tx_active), 0);
               check_eq("dv_has_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  ex = exp_q.pop_front();
                  check_eq("tx_byte", 32'(tx_byte), 32'(ex[7:0]));
                  check_eq("grant_at_dv", 32'(grant), 32'd1 << ex[11:8]);
               end
               pend_dv = 1'b1;
               stub_byte = tx_byte;
            end
            prev_dv = tx_dv;
         end else begin
            prev_dv = 1'b0;
         end
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         if (rst) begin
            tx_active = 1'b0; tx_done = 1'b0; stub_cnt = 0;
         end else begin
            tx_done = 1'b0;
            if (pend_dv) begin
               tx_active = 1'b1;
               stub_cnt = FRAME;
            end else if (tx_active) begin
               stub_cnt--;
               if (stub_cnt == 0) begin
                  tx_active = 1'b0;
                  tx_done = 1'b1;
               end
            end
         end
         for (int n = 0; n < N; n++) begin
            if (hs[n] && lane_q[n].size() > 0) e = lane_q[n].pop_front();
            coin = rand_stall && grant[n] && ($urandom_range(0, 3) == 0);
            req_valid[n] = (lane_q[n].size() > 0) && !stall_force[n] && !coin;
            e = (lane_q[n].size() > 0) ? lane_q[n][0] : 9'h000;
            req_byte[8*n +: 8] = e[7:0];
            req_last[n] = e[8];
         end
      end
   end

   // Serializer stub for the header-less instance.
   initial begin
      logic p;
      int c;
      n_active = 1'b0; n_done = 1'b0; c = 0;
      forever begin
         @(negedge clk);
         p = !rst && n_dv;
         if (p) begin
            n_dv_cnt++;
            n_last_byte = n_txb;
         end
         @(posedge clk);
         #1;
         if (rst) begin
            n_active = 1'b0; n_done = 1'b0; c = 0;
         end else begin
            n_done = 1'b0;
            if (p) begin
               n_active = 1'b1;
               c = FRAME;
            end else if (n_active) begin
               c--;
               if (c == 0) begin
                  n_active = 1'b0;
                  n_done = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      int dvs, bad, t, nf, len;
      n_valid = '0; n_byte = '0; n_last = '0;
      #2;
      check_eq("rst_tx_dv", 32'(tx_dv), 0);
      check_eq("rst_tx_byte", 32'(tx_byte), 0);
      check_eq("rst_grant", 32'(grant), 0);
      check_eq("rst_ready", 32'(req_ready), 0);
      check_eq("rst_busy", 32'(busy), 0);
      do_reset();

      // Single requester with header: A1 11 22 33.
      dvs = dv_cnt;
      push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h22, 1'b0); push_byte(1, 8'h33, 1'b1);
      model_append();
      wait_drain("single");
      check_eq("single_dv_count", 32'(dv_cnt - dvs), 4);

      // Two competing requesters, twice: pointer moves past the last winner.
      for (int r = 0; r < 2; r++) begin
         push_byte(0, 8'h40, 1'b1); push_byte(2, 8'h42, 1'b1);
         model_append();
         wait_drain("pair");
      end

      // All lanes loaded from reset: 0,1,2,3,0.
      do_reset();
      push_byte(0, 8'h50, 1'b1); push_byte(0, 8'h51, 1'b0); push_byte(0, 8'h52, 1'b1);
      for (int n = 1; n < N; n++) begin
         push_byte(n, 8'(8'h60 + n), 1'b0); push_byte(n, 8'(8'h70 + n), 1'b1);
      end
      model_append();
      wait_drain("all_lanes");

      // Lane 3 stalls mid-frame while lane 0 waits.
      push_byte(3, 8'h31, 1'b0); push_byte(3, 8'h32, 1'b0); push_byte(3, 8'h33, 1'b1);
      model_append();
      wait_lane(3, 2, "stall_first_byte");
      stall_force[3] = 1'b1;
      push_byte(0, 8'h0A, 1'b1);
      model_append();
      repeat (4) @(negedge clk);
      dvs = dv_cnt;
      bad = 0;
      repeat (5000) begin
         @(negedge clk);
         if (grant !== 4'b1000) bad++;
      end
      check_eq("stall_grant_lost_cycles", 32'(bad), 0);
      check_eq("stall_no_strobe", 32'(dv_cnt - dvs), 0);
      stall_force = '0;
      wait_drain("stall");

      // Header-less instance: one byte 5A.
      @(posedge clk); #1;
      n_byte[7:0] = 8'h5A; n_last = 2'b01; n_valid = 2'b01;
      t = 0;
      while (!n_ready[0] && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      check_eq("nohdr_accepted", 32'(t < LIMIT), 1);
      @(posedge clk); #1;
      n_valid = '0;
      t = 0;
      while ((n_busy || n_active) && t < LIMIT) begin
         @(negedge clk);
         t++;
      end
      check_eq("nohdr_dv_count", 32'(n_dv_cnt), 1);
      check_eq("nohdr_byte", 32'(n_last_byte), 32'h5A);
      check_eq("nohdr_grant_idle", 32'(n_grant), 0);

      // Randomized frames with random mid-frame stalls of the owner.
      rand_stall = 1'b1;
      for (int r = 0; r < 8; r++) begin
         for (int n = 0; n < N; n++) begin
            if ($urandom_range(0, 1) == 1) begin
               nf = $urandom_range(1, 2);
               for (int f = 0; f < nf; f++) begin
                  len = $urandom_range(1, 3);
                  for (int k = 0; k < len; k++)
                     push_byte(n, 8'($urandom_range(0, 255)), 1'(k == len - 1));
               end
            end
         end
         model_append();
         wait_drain("rand");
      end
      rand_stall = 1'b0;

      // Reset during WAIT of byte 2; pointer must restart at 0.
      push_byte(2, 8'h21, 1'b1);
      model_append();
      wait_drain("pre_abort");
      push_byte(1, 8'h71, 1'b0); push_byte(1, 8'h72, 1'b0); push_byte(1, 8'h73, 1'b1);
      model_append();
      wait_lane(1, 1, "abort_second_byte");
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("abort_tx_dv", 32'(tx_dv), 0);
      check_eq("abort_tx_byte", 32'(tx_byte), 0);
      check_eq("abort_grant", 32'(grant), 0);
      check_eq("abort_ready", 32'(req_ready), 0);
      check_eq("abort_busy", 32'(busy), 0);
      clear_all();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      push_byte(0, 8'h0B, 1'b1); push_byte(3, 8'h3B, 1'b1);
      model_append();
      wait_drain("after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
